simplecpu_loader: RTL and testbench

Program loader for the simplecpu core: it accepts a framed byte stream over a valid/ready interface and drives the core's `load_ram`/`load_addr`/`load_data` write port. It holds the core in reset through its `cpu_reset_n` output while loading and releases it once a complete, checksum-verified program image has been committed. It sits between the chip-level byte source (UART receiver, logic-analyzer bridge or wishbone shim) and simplecpu.

---
 rtl/simplecpu_pkg.sv | 37 +++
 rtl/simplecpu_loader_buf.sv | 25 ++
 rtl/simplecpu_loader.sv | 179 +++++++++++++++++
 tb/tb_simplecpu_loader.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/simplecpu_pkg.sv
// simplecpu_pkg: definitions shared by the simplecpu core and its program loader.
// Holds the loader state encoding, the default frame sync byte, the core RAM
// geometry (16 x 8), and the loader's RAM write-port bundle.
package simplecpu_pkg;

    localparam int RAM_AW = 4;
    localparam int RAM_DW = 8;

    localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_HDR    = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_CSUM   = 3'd3;
    localparam logic [2:0] ST_COMMIT = 3'd4;

    typedef enum logic [2:0] {
        IDLE   = ST_IDLE,
        HDR    = ST_HDR,
        DATA   = ST_DATA,
        CSUM   = ST_CSUM,
        COMMIT = ST_COMMIT
    } ld_state_e;

    typedef struct packed {
        logic              we;
        logic [RAM_AW-1:0] addr;
        logic [RAM_DW-1:0] data;
    } ram_wr_t;

    // Target address of a committed byte: wraps within the 16-entry RAM.
    function automatic logic [RAM_AW-1:0] wrap_addr(input logic [RAM_AW-1:0] base,
                                                    input logic [RAM_AW-1:0] idx);
        return base + idx;
    endfunction

endpackage

// File: rtl/simplecpu_loader_buf.sv
// simplecpu_loader_buf: 16x8 staging register file for one program frame.
// Ports: clock; we/waddr/wdata = synchronous write port;
//        raddr/rdata = combinational read port.
// Storage is deliberately not reset: contents are always rewritten by a frame
// before they can be committed.
module simplecpu_loader_buf
    import simplecpu_pkg::*;
(
    input  logic              clock,
    input  logic              we,
    input  logic [RAM_AW-1:0] waddr,
    input  logic [RAM_DW-1:0] wdata,
    input  logic [RAM_AW-1:0] raddr,
    output logic [RAM_DW-1:0] rdata
);

    logic [RAM_DW-1:0] mem [2**RAM_AW];

    always_ff @(posedge clock) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/simplecpu_loader.sv
// simplecpu_loader: framed byte-stream program loader for the simplecpu core.
// Frame: SYNC_BYTE, header {base,cnt}, cnt+1 data bytes, [checksum].
// Data is staged and only written to core RAM once the frame is complete, so a
// rejected frame never disturbs the loaded program. The core is held in reset
// (cpu_reset_n low) from the header of a frame until its commit finishes.
// Ports:
//   clock, reset (sync, active-low)
//   in_valid/in_data/in_ready : byte stream input
//   load_ram/load_addr/load_data : core RAM write port (zero outside COMMIT)
//   cpu_reset_n : core reset, busy : frame in progress
//   done : pulse on commit, err : pulse on checksum mismatch
// Build option: SIMPLECPU_LOADER_CSUM_EN enables the trailing XOR checksum byte
// and the err pulse; without it DATA goes straight to COMMIT and err is 0.
module simplecpu_loader
    import simplecpu_pkg::*;
#(
    parameter logic [7:0] SYNC_BYTE = DEFAULT_SYNC_BYTE
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              load_ram,
    output logic [RAM_AW-1:0] load_addr,
    output logic [RAM_DW-1:0] load_data,
    output logic              cpu_reset_n,
    output logic              busy,
    output logic              done,
    output logic              err
);

    ld_state_e         state, state_nxt;
    logic [RAM_AW-1:0] base_q, base_nxt;
    logic [RAM_AW-1:0] cnt_q, cnt_nxt;
    logic [RAM_AW-1:0] idx_q, idx_nxt;
    logic              rstn_q, rstn_nxt;
    logic              done_q, done_nxt;
`ifdef SIMPLECPU_LOADER_CSUM_EN
    logic [7:0]        csum_q, csum_nxt;
    logic              err_q, err_nxt;
`endif
    logic              accept;
    logic              buf_we;
    logic [RAM_DW-1:0] buf_rdata;
    ram_wr_t           wr;

    // Gated by reset so nothing is offered as accepted during the reset cycle.
    assign in_ready = reset && (state != COMMIT);
    assign accept   = in_valid && in_ready;

    always_comb begin
        state_nxt = state;
        base_nxt  = base_q;
        cnt_nxt   = cnt_q;
        idx_nxt   = idx_q;
        rstn_nxt  = rstn_q;
        done_nxt  = 1'b0;
        buf_we    = 1'b0;
`ifdef SIMPLECPU_LOADER_CSUM_EN
        csum_nxt  = csum_q;
        err_nxt   = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (accept && in_data == SYNC_BYTE) state_nxt = HDR;
            end
            HDR: begin
                if (accept) begin
                    base_nxt  = in_data[7:4];
                    cnt_nxt   = in_data[3:0];
                    idx_nxt   = '0;
                    rstn_nxt  = 1'b0;
                    state_nxt = DATA;
`ifdef SIMPLECPU_LOADER_CSUM_EN
                    csum_nxt  = in_data;
`endif
                end
            end
            DATA: begin
                if (accept) begin
                    buf_we = 1'b1;
`ifdef SIMPLECPU_LOADER_CSUM_EN
                    csum_nxt = csum_q ^ in_data;
`endif
                    if (idx_q == cnt_q) begin
`ifdef SIMPLECPU_LOADER_CSUM_EN
                        state_nxt = CSUM;
`else
                        idx_nxt   = '0;
                        state_nxt = COMMIT;
`endif
                    end else begin
                        idx_nxt = idx_q + 1'b1;
                    end
                end
            end
`ifdef SIMPLECPU_LOADER_CSUM_EN
            CSUM: begin
                if (accept) begin
                    if (in_data == csum_q) begin
                        idx_nxt   = '0;
                        state_nxt = COMMIT;
                    end else begin
                        // core stays in reset: its RAM may hold a stale program
                        err_nxt   = 1'b1;
                        state_nxt = IDLE;
                    end
                end
            end
`endif
            COMMIT: begin
                if (idx_q == cnt_q) begin
                    // release lands on the final write edge, so that write still hits
                    rstn_nxt  = 1'b1;
                    done_nxt  = 1'b1;
                    state_nxt = IDLE;
                end else begin
                    idx_nxt = idx_q + 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state  <= IDLE;
            base_q <= '0;
            cnt_q  <= '0;
            idx_q  <= '0;
            rstn_q <= 1'b0;
            done_q <= 1'b0;
`ifdef SIMPLECPU_LOADER_CSUM_EN
            csum_q <= '0;
            err_q  <= 1'b0;
`endif
        end else begin
            state  <= state_nxt;
            base_q <= base_nxt;
            cnt_q  <= cnt_nxt;
            idx_q  <= idx_nxt;
            rstn_q <= rstn_nxt;
            done_q <= done_nxt;
`ifdef SIMPLECPU_LOADER_CSUM_EN
            csum_q <= csum_nxt;
            err_q  <= err_nxt;
`endif
        end
    end

    simplecpu_loader_buf u_buf (
        .clock (clock),
        .we    (buf_we),
        .waddr (idx_q),
        .wdata (in_data),
        .raddr (idx_q),
        .rdata (buf_rdata)
    );

    always_comb begin
        wr.we   = (state == COMMIT);
        wr.addr = wr.we ? wrap_addr(base_q, idx_q) : '0;
        wr.data = wr.we ? buf_rdata : '0;
    end

    assign load_ram    = wr.we;
    assign load_addr   = wr.addr;
    assign load_data   = wr.data;
    assign cpu_reset_n = rstn_q;
    assign busy        = (state != IDLE);
    assign done        = done_q;
`ifdef SIMPLECPU_LOADER_CSUM_EN
    assign err         = err_q;
`else
    assign err         = 1'b0;
`endif

endmodule

// File: tb/tb_simplecpu_loader.sv
// Self-checking bench for simplecpu_loader. Works with and without
// SIMPLECPU_LOADER_CSUM_EN; frames are built with or without the checksum byte.
module tb_simplecpu_loader;

    localparam logic [7:0] SYNC = 8'hA5;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       in_ready, load_ram, cpu_reset_n, busy, done, err;
    logic [3:0] load_addr;
    logic [7:0] load_data;

    simplecpu_loader dut (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .load_ram(load_ram), .load_addr(load_addr),
        .load_data(load_data), .cpu_reset_n(cpu_reset_n), .busy(busy),
        .done(done), .err(err)
    );

    always #5 clock = ~clock;

`ifdef SIMPLECPU_LOADER_CSUM_EN
    localparam bit CSUM_ON = 1'b1;
`else
    localparam bit CSUM_ON = 1'b0;
`endif

    int total = 0;
    int bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- monitor ----------------
    int         cyc = 0;
    int         last_acc_cyc = 0;
    logic [11:0] obs_q[$];
    int         obs_cyc[$];
    int         done_n = 0, err_n = 0, done_cyc = -1, rst_viol = 0;

    always @(posedge clock) begin
        cyc = cyc + 1;
        if (in_valid && in_ready && reset) last_acc_cyc = cyc;
    end

    always @(negedge clock) begin
        if (load_ram) begin
            obs_q.push_back({load_addr, load_data});
            obs_cyc.push_back(cyc);
            if (cpu_reset_n) rst_viol++;
        end
        if (done) begin done_n++; done_cyc = cyc; end
        if (err) err_n++;
    end

    // ---------------- stimulus helpers ----------------
    task automatic send_byte(input logic [7:0] b, input int gap);
        int guard = 0;
        repeat (gap) begin @(negedge clock); in_valid = 1'b0; end
        @(negedge clock);
        in_valid = 1'b1;
        in_data  = b;
        while (!in_ready && guard < 100) begin @(negedge clock); guard++; end
        if (guard >= 100) chk("in_ready_timeout", 32'd0, 32'd1);
        @(posedge clock);
    endtask

    task automatic send_frame(input logic [3:0] base, input logic [3:0] cnt,
                              input logic [15:0][7:0] d, input logic [7:0] xmask,
                              input int maxgap);
        logic [7:0] cs;
        cs = {base, cnt};
        send_byte(SYNC, $urandom_range(0, maxgap));
        send_byte({base, cnt}, $urandom_range(0, maxgap));
        for (int i = 0; i <= int'(cnt); i++) begin
            send_byte(d[i], $urandom_range(0, maxgap));
            cs = cs ^ d[i];
        end
        if (CSUM_ON) send_byte(cs ^ xmask, $urandom_range(0, maxgap));
        @(negedge clock);
        in_valid = 1'b0;
    endtask

    task automatic wait_end(input int d0, input int e0);
        int g = 0;
        while (done_n == d0 && err_n == e0 && g < 80) begin
            @(negedge clock); #1; g++;
        end
        if (g >= 80) chk("completion_timeout", 32'd0, 32'd1);
        repeat (2) @(negedge clock);
        #1;
    endtask

    // ---------------- directed table ----------------
    typedef struct packed {
        logic [3:0]       base;
        logic [3:0]       cnt;
        logic [15:0][7:0] d;
        logic [7:0]       xmask;
        logic [3:0]       addr0;
        logic [4:0]       nw;
        logic             err;
    } vec_t;

    function automatic vec_t mk(input logic [3:0] base, input logic [3:0] cnt,
                                input logic [7:0] d0, input logic [7:0] d1,
                                input logic [7:0] d2, input logic [7:0] xmask,
                                input logic [3:0] addr0, input logic [4:0] nw,
                                input logic e);
        vec_t v;
        v.base = base; v.cnt = cnt; v.xmask = xmask;
        v.addr0 = addr0; v.nw = nw; v.err = e;
        for (int i = 0; i < 16; i++) v.d[i] = 8'h40 + 8'(i);
        v.d[0] = d0; v.d[1] = d1; v.d[2] = d2;
        return v;
    endfunction

    vec_t       vecs[5];
    logic [11:0] exp_q[$];

    initial begin
        int d0, e0, nw, exp_done, exp_err;
        logic [15:0][7:0] rd;
        logic [3:0] rb, rc;
        logic [7:0] rmask;

        vecs[0] = mk(4'h3, 4'h2, 8'h11, 8'h22, 8'h33, 8'h00, 4'h3, 5'd3, 1'b0);
        vecs[1] = mk(4'hE, 4'h2, 8'h01, 8'h02, 8'h03, 8'h00, 4'hE, 5'd3, 1'b0);
`ifdef SIMPLECPU_LOADER_CSUM_EN
        vecs[2] = mk(4'h1, 4'h0, 8'h55, 8'h00, 8'h00, 8'h45, 4'h0, 5'd0, 1'b1);
`else
        vecs[2] = mk(4'h1, 4'h0, 8'h55, 8'h00, 8'h00, 8'h45, 4'h1, 5'd1, 1'b0);
`endif
        vecs[3] = mk(4'h0, 4'hF, 8'h5A, 8'hA5, 8'hC3, 8'h00, 4'h0, 5'd16, 1'b0);
        vecs[4] = mk(4'h7, 4'h0, 8'hA5, 8'h00, 8'h00, 8'h00, 4'h7, 5'd1, 1'b0);

        // reset state
        @(posedge clock); @(negedge clock); #1;
        chk("rst_in_ready", in_ready, 0);
        chk("rst_load_ram", load_ram, 0);
        chk("rst_load_addr", load_addr, 0);
        chk("rst_load_data", load_data, 0);
        chk("rst_cpu_reset_n", cpu_reset_n, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done_err", {done, err}, 0);
        reset = 1'b1;
        @(negedge clock); #1;
        chk("post_rst_in_ready", in_ready, 1);
        chk("post_rst_cpu_reset_n", cpu_reset_n, 0);

        // directed vectors
        for (int v = 0; v < 5; v++) begin
            obs_q.delete(); obs_cyc.delete();
            d0 = done_n; e0 = err_n;
            if (v == 0) begin
                send_byte(8'h00, 0); send_byte(8'hFF, 0); send_byte(8'h5A, 0);
            end
            send_frame(vecs[v].base, vecs[v].cnt, vecs[v].d, vecs[v].xmask, 0);
            wait_end(d0, e0);
            nw = int'(vecs[v].nw);
            chk($sformatf("v%0d_nwrites", v), obs_q.size(), nw);
            for (int i = 0; i < nw && i < obs_q.size(); i++) begin
                chk($sformatf("v%0d_addr%0d", v, i), obs_q[i][11:8],
                    (int'(vecs[v].addr0) + i) % 16);
                chk($sformatf("v%0d_data%0d", v, i), obs_q[i][7:0], vecs[v].d[i]);
            end
            chk($sformatf("v%0d_err", v), err_n - e0, vecs[v].err);
            chk($sformatf("v%0d_done", v), done_n - d0, vecs[v].err ? 0 : 1);
            chk($sformatf("v%0d_cpu_reset_n", v), cpu_reset_n, !vecs[v].err);
            chk($sformatf("v%0d_busy", v), busy, 0);
            if (nw > 0 && obs_cyc.size() == nw) begin
                chk($sformatf("v%0d_first_wr_cyc", v), obs_cyc[0], last_acc_cyc);
                chk($sformatf("v%0d_wr_span", v), obs_cyc[nw-1] - obs_cyc[0], nw - 1);
                chk($sformatf("v%0d_done_cyc", v), done_cyc, obs_cyc[0] + nw);
            end
        end

        // randomized frames with input gaps against the write-list model
        obs_q.delete(); obs_cyc.delete(); exp_q.delete();
        d0 = done_n; e0 = err_n; exp_done = 0; exp_err = 0;
        for (int f = 0; f < 20; f++) begin
            int pd, pe;
            rb = 4'($urandom_range(0, 15));
            rc = 4'($urandom_range(0, 15));
            for (int i = 0; i < 16; i++) rd[i] = 8'($urandom_range(0, 255));
            rmask = ($urandom_range(0, 4) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
            if (CSUM_ON && rmask != 8'h00) exp_err++;
            else begin
                exp_done++;
                for (int i = 0; i <= int'(rc); i++)
                    exp_q.push_back({4'((int'(rb) + i) % 16), rd[i]});
            end
            pd = done_n; pe = err_n;
            send_frame(rb, rc, rd, rmask, 3);
            wait_end(pd, pe);
        end
        chk("rand_nwrites", obs_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
            chk($sformatf("rand_wr%0d", i), obs_q[i], exp_q[i]);
        chk("rand_done", done_n - d0, exp_done);
        chk("rand_err", err_n - e0, exp_err);

        // sync byte held during COMMIT, then reset in the second COMMIT cycle
        obs_q.delete(); obs_cyc.delete();
        begin
            logic [15:0][7:0] hd;
            hd = vecs[0].d;
            send_byte(SYNC, 0); send_byte(8'h32, 0);
            send_byte(hd[0], 0); send_byte(hd[1], 0); send_byte(hd[2], 0);
            if (CSUM_ON) send_byte(8'h32, 0);
        end
        @(negedge clock);
        in_valid = 1'b1; in_data = SYNC;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk($sformatf("hold_in_ready_c%0d", i), in_ready, 0);
            chk($sformatf("hold_load_ram_c%0d", i), load_ram, 1);
            @(negedge clock);
        end
        #1;
        chk("hold_done", done, 1);
        chk("hold_in_ready_idle", in_ready, 1);
        @(posedge clock); #1;
        chk("hold_sync_accepted", busy, 1);
        send_byte(8'h32, 0);
        send_byte(8'h11, 0); send_byte(8'h22, 0); send_byte(8'h33, 0);
        if (CSUM_ON) send_byte(8'h32, 0);
        @(negedge clock); in_valid = 1'b0;
        #1; chk("rc_commit1", load_ram, 1);
        @(negedge clock);
        #1; chk("rc_commit2", load_ram, 1);
        reset = 1'b0;
        @(posedge clock); #1;
        chk("rc_load_ram", load_ram, 0);
        chk("rc_busy", busy, 0);
        chk("rc_cpu_reset_n", cpu_reset_n, 0);
        chk("rc_in_ready", in_ready, 0);
        @(negedge clock); reset = 1'b1;
        @(negedge clock); #1;
        chk("rc_writes", obs_q.size(), 5);
        chk("rc_in_ready_after", in_ready, 1);
        chk("rst_viol", rst_viol, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
